// File: rtl/risc16_pkg.sv
// Shared definitions for the RISC16 host loader: command/response byte codes
// and the loader state encoding.
package risc16_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

  localparam logic [7:0] RSP_ACK   = 8'hA5;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_COUNT,
    ST_DATA,
    ST_WR,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_SEND,
    ST_RUN_WAIT,
    ST_ACK,
    ST_ERR
  } loader_state_e;

  typedef enum logic {
    OP_WRITE,
    OP_READ
  } loader_op_e;

endpackage

// File: rtl/byte_word_packer.sv
// Byte <-> 32-bit word converter, MSB first. Shifts host bytes in for writes
// and shifts a captured memory word out for read responses.
module byte_word_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        shift_in,
  input  logic        shift_out,
  input  logic [7:0]  byte_in,
  input  logic [31:0] word_in,
  output logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = word_in;
      idx_d  = '0;
    end else if (shift_in) begin
      word_d = {word_q[23:0], byte_in};
      idx_d  = idx_q + 2'd1;
    end else if (shift_out) begin
      word_d = {word_q[23:0], 8'h00};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word     = word_q;
  assign byte_out = word_q[31:24];
  // Byte index wraps after four transfers, so "last" marks the 4th byte of a word.
  assign last     = (idx_q == 2'd3);

endmodule

// File: rtl/risc_mem_loader.sv
// Byte-stream program loader / result reader for pipe_RISC16bit: decodes
// WRITE/READ/RUN commands into memory strobes and core run control.
module risc_mem_loader
  import risc16_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              busy
);

  loader_state_e     state_q, state_d;
  loader_op_e        op_q, op_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        count_q, count_d;
  logic              cpu_run_q, cpu_run_d;
  logic              armed_q, armed_d;
  logic              live_q;

  logic        pk_clear, pk_load, pk_shift_in, pk_shift_out, pk_last;
  logic [31:0] pk_word;
  logic [7:0]  pk_byte;

  logic accepting, in_fire;

  byte_word_packer u_packer (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .load      (pk_load),
    .shift_in  (pk_shift_in),
    .shift_out (pk_shift_out),
    .byte_in   (in_data),
    .word_in   (mem_rdata),
    .word      (pk_word),
    .byte_out  (pk_byte),
    .last      (pk_last)
  );

  // live_q holds in_ready low until the first edge after reset release.
  assign accepting = live_q && (state_q inside {ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_COUNT, ST_DATA});
  assign in_fire   = in_valid && accepting;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WRITE;
      hi_q      <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      cpu_run_q <= 1'b0;
      armed_q   <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      cpu_run_q <= cpu_run_d;
      armed_q   <= armed_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    count_d      = count_q;
    cpu_run_d    = cpu_run_q;
    armed_d      = armed_q;
    pk_clear     = 1'b0;
    pk_load      = 1'b0;
    pk_shift_in  = 1'b0;
    pk_shift_out = 1'b0;

    unique case (state_q)
      ST_IDLE: if (in_fire) begin
        case (in_data)
          CMD_WRITE: begin
            op_d      = OP_WRITE;
            cpu_run_d = 1'b0;
            state_d   = ST_ADDR_H;
          end
          CMD_READ: begin
            op_d    = OP_READ;
            state_d = ST_ADDR_H;
          end
          CMD_RUN: begin
            // Registered run stays high; the output gate below supplies the one-cycle restart gap.
            cpu_run_d = 1'b1;
            armed_d   = 1'b0;
            state_d   = ST_RUN_WAIT;
          end
          default: state_d = ST_ERR;
        endcase
      end
      ST_ADDR_H: if (in_fire) begin
        hi_d    = in_data;
        state_d = ST_ADDR_L;
      end
      ST_ADDR_L: if (in_fire) begin
        addr_d  = ADDR_W'({hi_q, in_data});
        state_d = (op_q == OP_WRITE) ? ST_COUNT : ST_RD_REQ;
      end
      ST_COUNT: if (in_fire) begin
        count_d  = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
        pk_clear = 1'b1;
        state_d  = ST_DATA;
      end
      ST_DATA: if (in_fire) begin
        pk_shift_in = 1'b1;
        if (pk_last) state_d = ST_WR;
      end
      ST_WR: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - 9'd1;
        state_d = (count_q == 9'd1) ? ST_ACK : ST_DATA;
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        pk_load = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (out_ready) begin
        pk_shift_out = 1'b1;
        if (pk_last) state_d = ST_IDLE;
      end
      ST_RUN_WAIT: begin
        // A halt counts only after the flag has been seen low while running.
        if (!cpu_halted) armed_d = 1'b1;
        if (armed_q && cpu_halted) state_d = ST_ACK;
      end
      ST_ACK, ST_ERR: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = accepting;
    out_valid = 1'b0;
    out_data  = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != ST_IDLE);
    cpu_run   = cpu_run_q;

    if (state_q == ST_IDLE && in_fire && (in_data == CMD_WRITE || in_data == CMD_RUN))
      cpu_run = 1'b0;

    unique case (state_q)
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = DATA_W'(pk_word);
      end
      ST_RD_REQ: begin
        mem_re   = 1'b1;
        mem_addr = addr_q;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = pk_byte;
      end
      ST_ACK: begin
        out_valid = 1'b1;
        out_data  = RSP_ACK;
      end
      ST_ERR: begin
        out_valid = 1'b1;
        out_data  = RSP_ERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_mem_loader.sv
// Directed bench for risc_mem_loader with a behavioural memory and a tiny
// core stand-in that computes n! from word 200 into word 198 and then halts.
module tb_risc_mem_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        mem_we, mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_run;
  logic        cpu_halted = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          re_count = 0;
  int          run_cnt = 0;

  risc_mem_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_run    (cpu_run),
    .cpu_halted (cpu_halted),
    .busy       (busy)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * i;
    return r;
  endfunction

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

  // Memory with one-cycle read latency plus a core that halts ~20 cycles after release.
  always @(posedge clk1) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_count  <= re_count + 1;
    end
    if (!cpu_run) begin
      run_cnt    <= 0;
      cpu_halted <= 1'b0;
    end else if (!cpu_halted) begin
      run_cnt <= run_cnt + 1;
      if (run_cnt == 20) begin
        mem[198]   <= fact(mem[200]);
        cpu_halted <= 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk1);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 for byte %02h, required 1", b);
    end
    @(posedge clk1);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    @(negedge clk1);
    out_ready = 1'b1;
    while (!out_valid && n < 200) begin
      @(negedge clk1);
      n++;
    end
    b = out_data;
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout: out_valid=0 after %0d cycles, required 1", n);
    end
    @(posedge clk1);
    #1 out_ready = 1'b0;
  endtask

  task automatic recv_word(output logic [31:0] w);
    logic [7:0] b;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      w = {w[23:0], b};
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk1);
    checks++;
    if ({in_ready, out_valid, mem_we, mem_re, cpu_run, busy} !== 6'b0 ||
        mem_addr !== 10'h0 || mem_wdata !== 32'h0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b ov=%b we=%b re=%b run=%b busy=%b addr=%h wd=%h, required all 0",
               in_ready, out_valid, mem_we, mem_re, cpu_run, busy, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b before first edge, required 0", in_ready);
    end
    @(posedge clk1);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_write_program();
    logic [31:0] prog [11] = '{32'h280800C8, 32'h28100001, 32'h0C210000, 32'h2C420001,
                               32'h3C030000, 32'h10830005, 32'h60840000, 32'h1C210001,
                               32'h040007F8, 32'h2C2000C6, 32'hFC000000};
    logic [7:0] rsp;
    int base = wr_addr.size();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'd11);
    for (int w = 0; w < 11; w++) begin
      for (int k = 3; k >= 0; k--) send_byte(prog[w][k*8 +: 8]);
      if (w == 0) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== prog[0]) begin
          errors++;
          $display("FAIL write_latency: we=%b addr=%h data=%h after 4th byte, required 1/000/%h",
                   mem_we, mem_addr, mem_wdata, prog[0]);
        end
      end
    end
    recv_byte(rsp);
    checks++;
    if (rsp !== 8'hA5) begin
      errors++;
      $display("FAIL write_prog_ack: got %02h, required a5", rsp);
    end
    checks++;
    if (wr_addr.size() - base != 11) begin
      errors++;
      $display("FAIL write_prog_count: %0d pulses, required 11", wr_addr.size() - base);
    end else begin
      for (int w = 0; w < 11; w++) begin
        checks++;
        if (wr_addr[base+w] !== 10'(w) || wr_data[base+w] !== prog[w]) begin
          errors++;
          $display("FAIL write_prog_word%0d: addr=%h data=%h, required %h/%h",
                   w, wr_addr[base+w], wr_data[base+w], 10'(w), prog[w]);
        end
      end
    end
  endtask

  task automatic test_run_factorial();
    logic [7:0]  rsp;
    logic [31:0] w;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hC8); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    recv_byte(rsp);
    checks++;
    if (rsp !== 8'hA5) begin
      errors++;
      $display("FAIL run_setup_ack: got %02h, required a5", rsp);
    end
    send_byte(8'h03);
    checks++;
    if (cpu_run !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_start: run=%b rdy=%b busy=%b, required 1/0/1", cpu_run, in_ready, busy);
    end
    recv_byte(rsp);
    checks++;
    if (rsp !== 8'hA5 || cpu_halted !== 1'b1) begin
      errors++;
      $display("FAIL run_halt_ack: got %02h halted=%b, required a5/1", rsp, cpu_halted);
    end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hC6);
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 10'd198) begin
      errors++;
      $display("FAIL read_latency: re=%b addr=%h, required 1/0c6", mem_re, mem_addr);
    end
    recv_word(w);
    checks++;
    if (w !== 32'h000013B0) begin
      errors++;
      $display("FAIL read_fact7: got %h, required 000013b0", w);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0]  rsp;
    logic [31:0] w;
    int wb = wr_addr.size();
    int rb = re_count;
    send_byte(8'h7F);
    recv_byte(rsp);
    checks++;
    if (rsp !== 8'hEE) begin
      errors++;
      $display("FAIL bad_cmd_rsp: got %02h, required ee", rsp);
    end
    @(negedge clk1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || wr_addr.size() != wb || re_count != rb) begin
      errors++;
      $display("FAIL bad_cmd_side: ov=%b busy=%b writes=%0d reads=%0d, required 0/0/0/0",
               out_valid, busy, wr_addr.size() - wb, re_count - rb);
    end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hC8);
    recv_word(w);
    checks++;
    if (w !== 32'h00000007) begin
      errors++;
      $display("FAIL bad_cmd_next_read: got %h, required 00000007", w);
    end
  endtask

  task automatic test_restart();
    logic [7:0] rsp;
    @(negedge clk1);
    checks++;
    if (cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre: cpu_run=%b, required 1", cpu_run);
    end
    in_valid = 1'b1;
    in_data  = 8'h03;
    #1;
    checks++;
    if (cpu_run !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_drop: cpu_run=%b rdy=%b, required 0/1", cpu_run, in_ready);
    end
    @(posedge clk1);
    #1 in_valid = 1'b0;
    checks++;
    if (cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL restart_rise: cpu_run=%b one cycle later, required 1", cpu_run);
    end
    recv_byte(rsp);
    checks++;
    if (rsp !== 8'hA5) begin
      errors++;
      $display("FAIL restart_ack: got %02h, required a5", rsp);
    end
  endtask

  task automatic test_write_wrap_backpressure();
    logic [7:0] rsp;
    logic [31:0] w0 = 32'hDEADBEEF;
    logic [31:0] w1 = 32'h01234567;
    bit stable = 1'b1;
    int base = wr_addr.size();
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = 8'h01;
    #1;
    checks++;
    if (cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL write_drops_run: cpu_run=%b in accept cycle, required 0", cpu_run);
    end
    @(posedge clk1);
    #1 in_valid = 1'b0;
    checks++;
    if (cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL write_run_held_low: cpu_run=%b, required 0", cpu_run);
    end
    send_byte(8'h07); send_byte(8'hFF); send_byte(8'h02);
    for (int k = 3; k >= 0; k--) send_byte(w0[k*8 +: 8]);
    for (int k = 3; k >= 0; k--) send_byte(w1[k*8 +: 8]);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'h000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_last_wr: we=%b addr=%h ov=%b, required 1/000/0", mem_we, mem_addr, out_valid);
    end
    @(negedge clk1);
    @(negedge clk1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL ack_latency: ov=%b data=%02h, required 1/a5", out_valid, out_data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      if (out_valid !== 1'b1 || out_data !== 8'hA5) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL ack_hold: ack not held stable under back-pressure (ov=%b data=%02h), required 1/a5",
               out_valid, out_data);
    end
    recv_byte(rsp);
    checks++;
    if (rsp !== 8'hA5) begin
      errors++;
      $display("FAIL ack_deliver: got %02h, required a5", rsp);
    end
    @(negedge clk1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_once: ov=%b busy=%b after delivery, required 0/0", out_valid, busy);
    end
    checks++;
    if (wr_addr.size() - base != 2) begin
      errors++;
      $display("FAIL wrap_count: %0d pulses, required 2", wr_addr.size() - base);
    end else begin
      checks++;
      if (wr_addr[base] !== 10'h3FF || wr_data[base] !== w0 ||
          wr_addr[base+1] !== 10'h000 || wr_data[base+1] !== w1) begin
        errors++;
        $display("FAIL wrap_words: %h/%h %h/%h, required 3ff/%h 000/%h",
                 wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1], w0, w1);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    int base = wr_addr.size();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, mem_we, mem_re, cpu_run, busy} !== 6'b0 ||
        mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b ov=%b we=%b re=%b run=%b busy=%b, required all 0",
               in_ready, out_valid, mem_we, mem_re, cpu_run, busy);
    end
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
    checks++;
    if (wr_addr.size() != base) begin
      errors++;
      $display("FAIL midreset_no_write: %0d pulses, required 0", wr_addr.size() - base);
    end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hFF);
    recv_word(w);
    checks++;
    if (w !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midreset_read: got %h, required deadbeef", w);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_program();
    test_run_factorial();
    test_bad_cmd();
    test_restart();
    test_write_wrap_backpressure();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
